// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the dual-issue fetch stage: PC-select encodings,
// default address width and the per-slot F->D record.
package fetch_unit_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [1:0] PCSRC_PLUS   = 2'b00;
    localparam logic [1:0] PCSRC_TARGET = 2'b01;
    localparam logic [1:0] PCSRC_ALU    = 2'b10;

    typedef struct packed {
        logic [31:0]         instr;
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] pcplus4;
        logic                valid;
    } fetch_slot_t;

    function automatic logic is_redirect(input logic [1:0] src);
        return (src == PCSRC_TARGET) || (src == PCSRC_ALU);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response plus the two decode slots.
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    logic [XLEN-1:0] PCF;
    logic [XLEN-1:0] PCF2;
    logic [31:0]     InstrF1;
    logic [31:0]     InstrF2;
    logic [31:0]     InstrD1;
    logic [31:0]     InstrD2;
    logic [XLEN-1:0] PCD1;
    logic [XLEN-1:0] PCD2;
    logic [XLEN-1:0] PCPlus4D1;
    logic [XLEN-1:0] PCPlus4D2;
    logic            ValidD1;
    logic            ValidD2;

    modport master (
        output PCF, PCF2,
        input  InstrF1, InstrF2,
        output InstrD1, InstrD2, PCD1, PCD2, PCPlus4D1, PCPlus4D2, ValidD1, ValidD2
    );

    modport slave (
        input  PCF, PCF2,
        output InstrF1, InstrF2,
        input  InstrD1, InstrD2, PCD1, PCD2, PCPlus4D1, PCPlus4D2, ValidD1, ValidD2
    );
endinterface

// File: rtl/fetch_unit_redirect_sel.sv
// Combinational redirect arbitration between the two execute slots; slot 1 is
// older, so its redirect squashes anything slot 2 asks for.
module fetch_redirect_sel
    import fetch_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
)(
    input  logic [1:0]      PCSrcE1,
    input  logic [XLEN-1:0] PCTargetE1,
    input  logic [XLEN-1:0] ALUResultE1,
    input  logic [1:0]      PCSrcE2,
    input  logic [XLEN-1:0] PCTargetE2,
    input  logic [XLEN-1:0] ALUResultE2,
    output logic            redirect,
    output logic            redirect_slot,
    output logic [XLEN-1:0] target,
    output logic            misalign
);
    localparam logic [XLEN-1:0] BIT0_MASK = {{(XLEN-1){1'b1}}, 1'b0};
    localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    // jalr targets drop bit 0 before use
    function automatic logic [XLEN-1:0] slot_target(
        input logic [1:0]      src,
        input logic [XLEN-1:0] tgt,
        input logic [XLEN-1:0] alu
    );
        if (src == PCSRC_ALU) return alu & BIT0_MASK;
        return tgt;
    endfunction

    logic            take1;
    logic            take2;
    logic [XLEN-1:0] raw_target;

    always_comb begin
        take1         = is_redirect(PCSrcE1);
        take2         = is_redirect(PCSrcE2);
        redirect      = take1 || take2;
        redirect_slot = !take1 && take2;
        raw_target    = take1 ? slot_target(PCSrcE1, PCTargetE1, ALUResultE1)
                              : slot_target(PCSrcE2, PCTargetE2, ALUResultE2);
        target        = raw_target & WORD_MASK;
        misalign      = raw_target[1];
    end

endmodule

// File: rtl/fetch_unit.sv
// Dual-issue fetch stage: PC register and F->D pipeline register.
// Optional FETCH_PERF_CNT_EN adds saturating redirect/stall counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic [1:0]      PCSrcE1,
    input  logic [XLEN-1:0] PCTargetE1,
    input  logic [XLEN-1:0] ALUResultE1,
    input  logic [1:0]      PCSrcE2,
    input  logic [XLEN-1:0] PCTargetE2,
    input  logic [XLEN-1:0] ALUResultE2,
    fetch_unit_if.master    fbus,
    output logic            RedirectE,
    output logic            RedirectSlotE,
    output logic            MisalignF
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     RedirectCnt,
    output logic [31:0]     StallCnt
`endif
);
    logic            redirect;
    logic            redirect_slot;
    logic            target_misalign;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] pc_p0;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_plus8;
    logic            misalign_p0;
    fetch_slot_t     slot1_p1;
    fetch_slot_t     slot2_p1;

    fetch_redirect_sel #(.XLEN(XLEN)) u_redirect_sel (
        .PCSrcE1       (PCSrcE1),
        .PCTargetE1    (PCTargetE1),
        .ALUResultE1   (ALUResultE1),
        .PCSrcE2       (PCSrcE2),
        .PCTargetE2    (PCTargetE2),
        .ALUResultE2   (ALUResultE2),
        .redirect      (redirect),
        .redirect_slot (redirect_slot),
        .target        (redirect_target),
        .misalign      (target_misalign)
    );

    assign pc_plus4 = pc_p0 + XLEN'(4);
    assign pc_plus8 = pc_p0 + XLEN'(8);

    // F stage: redirect beats StallF, otherwise advance by the issue width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_p0       <= RESET_PC;
            misalign_p0 <= 1'b0;
        end else if (redirect) begin
            pc_p0       <= redirect_target;
            misalign_p0 <= target_misalign;
        end else if (!StallF) begin
            pc_p0       <= pc_plus8;
        end
    end

    // F->D boundary: squash beats StallD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot1_p1 <= '0;
            slot2_p1 <= '0;
        end else if (redirect || FlushD) begin
            slot1_p1 <= '0;
            slot2_p1 <= '0;
        end else if (!StallD) begin
            slot1_p1 <= '{instr: fbus.InstrF1, pc: pc_p0,    pcplus4: pc_plus4, valid: 1'b1};
            slot2_p1 <= '{instr: fbus.InstrF2, pc: pc_plus4, pcplus4: pc_plus8, valid: 1'b1};
        end
    end

    assign fbus.PCF       = pc_p0;
    assign fbus.PCF2      = pc_plus4;
    assign fbus.InstrD1   = slot1_p1.instr;
    assign fbus.InstrD2   = slot2_p1.instr;
    assign fbus.PCD1      = slot1_p1.pc;
    assign fbus.PCD2      = slot2_p1.pc;
    assign fbus.PCPlus4D1 = slot1_p1.pcplus4;
    assign fbus.PCPlus4D2 = slot2_p1.pcplus4;
    assign fbus.ValidD1   = slot1_p1.valid;
    assign fbus.ValidD2   = slot2_p1.valid;
    assign RedirectE      = redirect;
    assign RedirectSlotE  = redirect_slot;
    assign MisalignF      = misalign_p0;

`ifdef FETCH_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    logic [31:0] redirect_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            if (redirect)            redirect_cnt_q <= sat_inc(redirect_cnt_q);
            if (StallF && !redirect) stall_cnt_q    <= sat_inc(stall_cnt_q);
        end
    end

    assign RedirectCnt = redirect_cnt_q;
    assign StallCnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random stimulus
// against a cycle-level behavioural model of the fetch stage.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0;
    logic [1:0]  PCSrcE1 = 2'b00, PCSrcE2 = 2'b00;
    logic [31:0] PCTargetE1 = '0, ALUResultE1 = '0, PCTargetE2 = '0, ALUResultE2 = '0;
    logic        RedirectE, RedirectSlotE, MisalignF;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] RedirectCnt, StallCnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit_if #(.XLEN(32)) bus();

    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    assign bus.InstrF1 = imem(bus.PCF);
    assign bus.InstrF2 = imem(bus.PCF2);

    fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .StallF      (StallF),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .PCSrcE1     (PCSrcE1),
        .PCTargetE1  (PCTargetE1),
        .ALUResultE1 (ALUResultE1),
        .PCSrcE2     (PCSrcE2),
        .PCTargetE2  (PCTargetE2),
        .ALUResultE2 (ALUResultE2),
        .fbus        (bus),
        .RedirectE   (RedirectE),
        .RedirectSlotE (RedirectSlotE),
        .MisalignF   (MisalignF)
`ifdef FETCH_PERF_CNT_EN
        ,
        .RedirectCnt (RedirectCnt),
        .StallCnt    (StallCnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference state: architectural PC, sticky misalign flag, two decode slots
    logic [31:0] m_pc;
    logic        m_mis;
    logic [31:0] m_instr [2];
    logic [31:0] m_dpc   [2];
    logic [31:0] m_dp4   [2];
    logic        m_valid [2];
    logic [31:0] m_rc, m_sc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc  = RESET_PC;
        m_mis = 1'b0;
        m_rc  = '0;
        m_sc  = '0;
        for (int i = 0; i < 2; i++) begin
            m_instr[i] = '0; m_dpc[i] = '0; m_dp4[i] = '0; m_valid[i] = 1'b0;
        end
    endtask

    task automatic check_regs();
        check("PCF", bus.PCF, m_pc);
        check("PCF2", bus.PCF2, m_pc + 32'd4);
        check("MisalignF", MisalignF, m_mis);
        check("InstrD1", bus.InstrD1, m_instr[0]);
        check("InstrD2", bus.InstrD2, m_instr[1]);
        check("PCD1", bus.PCD1, m_dpc[0]);
        check("PCD2", bus.PCD2, m_dpc[1]);
        check("PCPlus4D1", bus.PCPlus4D1, m_dp4[0]);
        check("PCPlus4D2", bus.PCPlus4D2, m_dp4[1]);
        check("ValidD1", bus.ValidD1, m_valid[0]);
        check("ValidD2", bus.ValidD2, m_valid[1]);
`ifdef FETCH_PERF_CNT_EN
        check("RedirectCnt", RedirectCnt, m_rc);
        check("StallCnt", StallCnt, m_sc);
`endif
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cycle(input logic sf, input logic sd, input logic fd,
                         input logic [1:0] s1, input logic [31:0] t1, input logic [31:0] a1,
                         input logic [1:0] s2, input logic [31:0] t2, input logic [31:0] a2);
        logic        r1, r2;
        logic [31:0] raw;
        StallF = sf; StallD = sd; FlushD = fd;
        PCSrcE1 = s1; PCTargetE1 = t1; ALUResultE1 = a1;
        PCSrcE2 = s2; PCTargetE2 = t2; ALUResultE2 = a2;
        #1;
        r1  = (s1 == 2'b01) || (s1 == 2'b10);
        r2  = (s2 == 2'b01) || (s2 == 2'b10);
        raw = r1 ? ((s1 == 2'b01) ? t1 : (a1 & ~32'd1))
                 : ((s2 == 2'b01) ? t2 : (a2 & ~32'd1));
        check("RedirectE", RedirectE, r1 || r2);
        check("RedirectSlotE", RedirectSlotE, !r1 && r2);
        if (r1 || r2 || fd) begin
            for (int i = 0; i < 2; i++) begin
                m_instr[i] = '0; m_dpc[i] = '0; m_dp4[i] = '0; m_valid[i] = 1'b0;
            end
        end else if (!sd) begin
            for (int i = 0; i < 2; i++) begin
                m_dpc[i]   = m_pc + 32'(4 * i);
                m_dp4[i]   = m_pc + 32'(4 * i + 4);
                m_instr[i] = imem(m_dpc[i]);
                m_valid[i] = 1'b1;
            end
        end
        if (r1 || r2) begin
            if (m_rc != 32'hFFFF_FFFF) m_rc = m_rc + 1;
        end else if (sf) begin
            if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
        end
        if (r1 || r2) begin
            m_pc  = {raw[31:2], 2'b00};
            m_mis = raw[1];
        end else if (!sf) begin
            m_pc  = m_pc + 32'd8;
        end
        @(posedge clk);
        @(negedge clk);
        check_regs();
    endtask

    task automatic free_cycle();
        cycle(1'b0, 1'b0, 1'b0, 2'b00, '0, '0, 2'b00, '0, '0);
    endtask

    task automatic jump(input logic [31:0] tgt);
        cycle(1'b0, 1'b0, 1'b0, 2'b01, tgt, '0, 2'b00, '0, '0);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        PCSrcE1 = 2'b00; PCSrcE2 = 2'b00;
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        rst_n = 1'b1;
    endtask

    function automatic logic [1:0] rand_src();
        if ($urandom_range(0, 9) < 3) return 2'($urandom_range(1, 2));
        return $urandom_range(0, 1) ? 2'b00 : 2'b11;
    endfunction

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_regs();
        check("reset PCF", bus.PCF, RESET_PC);
        rst_n = 1'b1;

        // Straight-line fetch
        free_cycle();
        check("seq PCF=8", bus.PCF, 32'd8);
        check("seq PCD1=0", bus.PCD1, 32'd0);
        check("seq PCD2=4", bus.PCD2, 32'd4);
        check("seq ValidD", {bus.ValidD1, bus.ValidD2}, 2'b11);
        free_cycle();
        check("seq PCF=16", bus.PCF, 32'd16);

        // Slot 1 wins over slot 2
        jump(32'h40);
        check("jump PCF=0x40", bus.PCF, 32'h40);
        cycle(1'b0, 1'b0, 1'b0, 2'b01, 32'h100, '0, 2'b10, '0, 32'h200);
        check("prio PCF", bus.PCF, 32'h100);
        check("prio ValidD", {bus.ValidD1, bus.ValidD2}, 2'b00);

        // Misaligned jalr from slot 2, then cleared by a later redirect
        cycle(1'b0, 1'b0, 1'b0, 2'b00, '0, '0, 2'b10, '0, 32'h0000_0123);
        check("mis PCF", bus.PCF, 32'h120);
        check("mis flag set", MisalignF, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 2'b10, '0, 32'h81, 2'b00, '0, '0);
        check("mis PCF=0x80", bus.PCF, 32'h80);
        check("mis flag clear", MisalignF, 1'b0);

        // Full stall, then redirect during stall
        jump(32'h18);
        free_cycle();
        check("stall pre PCF", bus.PCF, 32'h20);
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 2'b00, '0, '0, 2'b00, '0, '0);
        check("stall PCF held", bus.PCF, 32'h20);
        check("stall PCD1 held", bus.PCD1, 32'h18);
        cycle(1'b1, 1'b1, 1'b0, 2'b01, 32'h300, '0, 2'b00, '0, '0);
        check("stall redirect PCF", bus.PCF, 32'h300);
        check("stall redirect ValidD", {bus.ValidD1, bus.ValidD2}, 2'b00);

        // FlushD beats StallD; StallF alone reloads the same pair
        free_cycle();
        cycle(1'b0, 1'b1, 1'b1, 2'b00, '0, '0, 2'b00, '0, '0);
        check("flush ValidD", {bus.ValidD1, bus.ValidD2}, 2'b00);
        cycle(1'b1, 1'b0, 1'b0, 2'b00, '0, '0, 2'b00, '0, '0);
        check("stallF reload PCD1", bus.PCD1, bus.PCF);

        // Address wrap
        jump(32'hFFFF_FFF8);
        free_cycle();
        check("wrap PCF", bus.PCF, 32'h0);
        check("wrap PCPlus4D2", bus.PCPlus4D2, 32'h0);

        // Asynchronous reset between edges while a redirect is pending
        PCSrcE1 = 2'b01; PCTargetE1 = 32'h500;
        #2;
        rst_n = 1'b0;
        #1;
        check("async PCF", bus.PCF, RESET_PC);
        check("async ValidD", {bus.ValidD1, bus.ValidD2}, 2'b00);
        reset_pulse();
        check_regs();

`ifdef FETCH_PERF_CNT_EN
        for (int i = 0; i < 5; i++) jump(32'(i * 64 + 32'h1000));
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0, 2'b00, '0, '0, 2'b00, '0, '0);
        check("perf RedirectCnt", RedirectCnt, 32'd5);
        check("perf StallCnt", StallCnt, 32'd7);
`endif

        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                  rand_src(), $urandom, $urandom, rand_src(), $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Dual-issue instruction fetch stage. Owns the PC register and the F→D pipeline register.
- Consumes the per-slot redirect outputs of the execute stage (PCSrcE1/2, PCTargetE1/2, ALUResultE1/2).
- Fetches two words per cycle (PC, PC+4) from a combinational instruction memory and presents them to decode as slot 1 (older) and slot 2 (younger).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, address/data width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- StallF  in  1  hold PC (from hazard unit)
- StallD  in  1  hold F→D register
- FlushD  in  1  external bubble into D
- PCSrcE1  in  2  slot-1 redirect select: 00 none, 01 PCTargetE1, 10 ALUResultE1, 11 none
- PCTargetE1  in  XLEN  branch/jal target, slot 1
- ALUResultE1  in  XLEN  jalr target, slot 1
- PCSrcE2, PCTargetE2, ALUResultE2  in  2/XLEN/XLEN  same for slot 2
- InstrF1  in  32  imem word at PCF
- InstrF2  in  32  imem word at PCF+4
- PCF  out  XLEN  fetch address, slot 1
- PCF2  out  XLEN  PCF+4
- InstrD1, InstrD2  out  32  decode instructions
- PCD1, PCD2  out  XLEN  decode PCs
- PCPlus4D1, PCPlus4D2  out  XLEN  PCD+4 per slot
- ValidD1, ValidD2  out  1  slot holds a real instruction
- RedirectE  out  1  a redirect was taken this cycle (combinational; hazard unit flushes E)
- RedirectSlotE  out  1  0 = slot 1 redirected, 1 = slot 2
- MisalignF  out  1  sticky: last redirect target had bit 1 set

Behaviour:
- Reset (async, rst_n low):
  - PCF=RESET_PC.
  - All D outputs 0; ValidD1=ValidD2=0; MisalignF=0.
- Target select per slot:
  - 01 → PCTarget.
  - 10 → ALUResult with bit 0 cleared.
  - 00/11 → no redirect.
- Next-PC priority, highest first:
  1. Slot-1 redirect. Slot-2 PCSrc is ignored because slot 2 is younger and squashed.
  2. Slot-2 redirect.
  3. StallF → hold PCF.
  4. PCF+8.
- A redirect overrides StallF.
- RedirectE = (PCSrcE1∈{01,10}) | (PCSrcE2∈{01,10}). RedirectSlotE=1 only when slot 2 alone redirects.
- MisalignF:
  - Updated on every redirect: set to bit 1 of the chosen target, else holds.
  - PC is still loaded with the target, bits [1:0] forced to 00.
- F→D register, priority highest first:
  1. Redirect or FlushD → ValidD1=ValidD2=0; other D fields don't-care but zeroed. This overrides StallD.
  2. StallD → hold all D outputs.
  3. Otherwise:
     - Load InstrF1/InstrF2, PCF/PCF2, PCF+4/PCF+8.
     - ValidD1=ValidD2=1.
- Latency: one cycle from PCF to D. Redirect takes effect at the next edge. Redirect penalty is 2 bubbles (D plus E flushed via RedirectE).
- Arithmetic: PC additions are modulo 2^XLEN. PCF=32'hFFFF_FFF8 wraps to 0 with no flag.
- Simultaneous events:
  - StallF=1 with StallD=0 is legal: D reloads the same PC pair.
  - Reset mid-redirect: reset wins.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Enabled:
  - Adds outputs RedirectCnt (32) and StallCnt (32), both 0 on reset.
  - RedirectCnt increments on each cycle with RedirectE=1.
  - StallCnt increments on each cycle with StallF=1 and RedirectE=0.
  - Both saturate at 32'hFFFF_FFFF.
- Disabled: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package:
  - PCSrc encoding constants (PCSRC_PLUS, PCSRC_TARGET, PCSRC_ALU).
  - XLEN default.
  - Typedef fetch_slot_t {instr, pc, pcplus4, valid}.
- One sub-module, fetch_redirect_sel (combinational): takes both slots' PCSrc/targets, returns redirect, slot, target, misalign. Shared by fetch and any future branch-predictor checker.

Test Plan:
- Reset release, no stalls, imem returns PC-indexed words → PCF sequence 0, 8, 16; D shows PCD1=0/PCD2=4 one cycle after PCF=0, ValidD=11.
- PCF=0x40, PCSrcE1=01 PCTargetE1=0x100, simultaneously PCSrcE2=10 ALUResultE2=0x200 → next PCF=0x100, RedirectSlotE=0, ValidD=00 next cycle.
- PCSrcE2=10, ALUResultE2=0x0000_0123, PCSrcE1=00 → PCF=0x120, MisalignF=1, RedirectSlotE=1. A later redirect to 0x80 clears MisalignF.
- StallF=StallD=1 for 3 cycles at PCF=0x20 → PCF and D held. A redirect to 0x300 during the stall → PCF=0x300, ValidD=00.
- FlushD=1 with StallD=1 → ValidD=00. rst_n asserted mid-stream (asynchronously, between edges) → PCF=RESET_PC immediately.
- With FETCH_PERF_CNT_EN: 5 redirects and 7 non-redirect stall cycles → RedirectCnt=5, StallCnt=7.
